// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   UART_MAX_DATA_BITS : default maximum data bits per frame
//   rx_deser_state_e   : frame FSM states used by rx_deser
//   clamp_len()        : maps a runtime frame length onto 1..size, where a
//                        length of 0 or one larger than size means "size"
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_MAX_DATA_BITS = 8;

    typedef enum logic {
        RXD_IDLE  = 1'b0,
        RXD_SHIFT = 1'b1
    } rx_deser_state_e;

    // Out-of-range lengths fall back to the full word so a misprogrammed
    // length register still produces complete frames.
    function automatic int clamp_len(input int len, input int size);
        if (len == 0 || len > size) begin
            return size;
        end
        return len;
    endfunction

endpackage

// File: rtl/rx_out_buf.sv
// -----------------------------------------------------------------------------
// rx_out_buf
// Single-entry valid/ready holding register for completed RX words, with
// sticky overrun detection.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : synchronous clear of the sticky overrun flag
//   i_load       : a completed word is offered this cycle
//   i_word       : the completed word
//   i_ready      : consumer accepts the held word at this edge
//   o_data       : held word, stable while o_valid is high
//   o_valid      : o_data holds an unconsumed word
//   o_overrun    : sticky, a word was offered while the buffer was full
// -----------------------------------------------------------------------------
module rx_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_accept;
    logic             w_drop;

    // A word can only be taken when the slot is empty or is being drained on
    // the same edge; otherwise the incoming word is lost and flagged.
    assign w_accept = r_valid && i_ready;
    assign w_drop   = i_load && r_valid && !i_ready;

    // Holding register and sticky overrun flag. Clearing the overrun flag
    // leaves the held word and its valid flag alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_load && !w_drop) begin
                r_data  <= i_word;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            if (i_clr) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/rx_deser.sv
// -----------------------------------------------------------------------------
// rx_deser
// Serial-to-parallel deserialiser for the UART RX path. Shifts in one bit per
// strobe, counts bits against a length latched at frame start, and hands each
// completed word to a single-entry valid/ready buffer.
// Parameters:
//   SIZE      : maximum data bits per frame, width of DATA_OUT (1..32)
//   MSB_FIRST : 0 = first received bit lands in word LSB, 1 = in word MSB
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset
//   SHIFT_EN   : sample strobe, DATA_IN captured on edges where high
//   DATA_IN    : serial data bit
//   LEN        : runtime frame length, 0 or >SIZE means SIZE
//   CLR        : synchronous frame abort and overrun clear
//   SR_OUT     : raw shift register contents
//   BIT_CNT    : bits captured in the current frame
//   DATA_OUT   : completed word, right-justified, upper bits zero
//   OUT_VALID  : DATA_OUT holds an unconsumed word
//   OUT_READY  : consumer accepts the word
//   FRAME_DONE : one-cycle pulse after a frame completes
//   OVERRUN    : sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module rx_deser
    import uart_pkg::*;
#(
    parameter int  SIZE      = UART_MAX_DATA_BITS,
    parameter bit  MSB_FIRST = 1'b0,
    localparam int CNT_W     = $clog2(SIZE + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SHIFT_EN,
    input  logic             DATA_IN,
    input  logic [CNT_W-1:0] LEN,
    input  logic             CLR,
    output logic [SIZE-1:0]  SR_OUT,
    output logic [CNT_W-1:0] BIT_CNT,
    output logic [SIZE-1:0]  DATA_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             FRAME_DONE,
    output logic             OVERRUN
);

    rx_deser_state_e r_state;
    rx_deser_state_e w_stateNext;

    logic [SIZE-1:0]  r_sr;
    logic [CNT_W-1:0] r_bitCnt;
    logic [CNT_W-1:0] r_lenQ;
    logic             r_frameDone;

    logic [SIZE-1:0]  w_srBase;
    logic [SIZE-1:0]  w_srNext;
    logic [SIZE-1:0]  w_word;
    logic [SIZE-1:0]  w_mask;
    logic [CNT_W-1:0] w_lenStart;
    logic [CNT_W-1:0] w_lenEff;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_shamt;
    logic             w_last;
    logic             w_load;

    assign w_lenStart = CNT_W'(clamp_len(int'(LEN), SIZE));

    // Datapath: in IDLE the next strobe starts a fresh frame, so the shift
    // base is zero and the length comes straight from LEN. That lets a
    // one-bit frame complete on its very first strobe. The completed word is
    // built from the post-shift value so it is ready on the last-bit edge.
    always_comb begin
        w_srBase  = (r_state == RXD_IDLE) ? '0 : r_sr;
        w_lenEff  = (r_state == RXD_IDLE) ? w_lenStart : r_lenQ;
        w_cntNext = ((r_state == RXD_IDLE) ? '0 : r_bitCnt) + CNT_W'(1);
        w_last    = (w_cntNext == w_lenEff);
        w_mask    = ~({SIZE{1'b1}} << w_lenEff);
        w_shamt   = CNT_W'(SIZE) - w_lenEff;
        if (MSB_FIRST) begin
            w_srNext    = w_srBase << 1;
            w_srNext[0] = DATA_IN;
            w_word      = w_srNext & w_mask;
        end else begin
            // LSB-first bits enter at the top, so a short frame sits in the
            // upper bits and is right-justified by the shift.
            w_srNext         = w_srBase >> 1;
            w_srNext[SIZE-1] = DATA_IN;
            w_word           = w_srNext >> w_shamt;
        end
    end

    // Next-state logic: abort beats a strobe on the same edge, and a strobe
    // that completes the frame returns to IDLE and offers the word.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        if (CLR) begin
            w_stateNext = RXD_IDLE;
        end else if (SHIFT_EN) begin
            if (w_last) begin
                w_stateNext = RXD_IDLE;
                w_load      = 1'b1;
            end else begin
                w_stateNext = RXD_SHIFT;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RXD_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Shift register, bit counter and latched length. The length is only
    // captured at frame start so mid-frame LEN changes are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sr        <= '0;
            r_bitCnt    <= '0;
            r_lenQ      <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_load;
            if (CLR) begin
                r_sr     <= '0;
                r_bitCnt <= '0;
            end else if (SHIFT_EN) begin
                r_sr     <= w_srNext;
                r_bitCnt <= w_last ? '0 : w_cntNext;
                if (r_state == RXD_IDLE) begin
                    r_lenQ <= w_lenStart;
                end
            end
        end
    end

    rx_out_buf #(
        .WIDTH (SIZE)
    ) u_outBuf (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_clr     (CLR),
        .i_load    (w_load),
        .i_word    (w_word),
        .i_ready   (OUT_READY),
        .o_data    (DATA_OUT),
        .o_valid   (OUT_VALID),
        .o_overrun (OVERRUN)
    );

    assign SR_OUT     = r_sr;
    assign BIT_CNT    = r_bitCnt;
    assign FRAME_DONE = r_frameDone;

endmodule
